// File: rtl/d_flip_flop_pkg.sv
// Shared defaults and data-word type for the register primitives.
package d_flip_flop_pkg;

   localparam int DFF_DEFAULT_WIDTH  = 1;
   localparam int DFF_DEFAULT_STAGES = 1;

   typedef logic [DFF_DEFAULT_WIDTH-1:0] dff_word_t;

endpackage : d_flip_flop_pkg

// File: rtl/d_flip_flop_cell.sv
// Single WIDTH-bit register stage with synchronous reset and optional capture enable.
module d_flip_flop_cell
   import d_flip_flop_pkg::*;
#(
   parameter int               WIDTH       = DFF_DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter bit               USE_EN      = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] stage_q;
   logic [WIDTH-1:0] stage_d;

   // NOTE: hold is the default so every path assigns stage_d and no latch is inferred.
   always_comb begin
      stage_d = stage_q;
      if (!USE_EN || en_i) begin
         stage_d = d_i;
      end
   end

   // NOTE: reset is sampled on the clock edge and beats enable; state uses <= only.
   always_ff @(posedge clk) begin
      if (rst) begin
         stage_q <= RESET_VALUE;
      end else begin
         stage_q <= stage_d;
      end
   end

   assign q_o = stage_q;

endmodule : d_flip_flop_cell

// File: rtl/d_flip_flop.sv
// Parameterisable D flip-flop / delay line: STAGES cascaded cells, q_n is ~q.
module d_flip_flop
   import d_flip_flop_pkg::*;
#(
   parameter int               WIDTH       = DFF_DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter int               STAGES      = DFF_DEFAULT_STAGES,
   parameter bit               USE_EN      = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_n
);

   if (WIDTH < 1 || STAGES < 1) begin : g_bad_param
      $error("d_flip_flop: WIDTH and STAGES must both be >= 1");
   end

   logic [WIDTH-1:0] stage_q [STAGES];

   // A shared enable freezes the whole chain together, so no bubbles are created.
   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      logic [WIDTH-1:0] stage_in;

      if (i == 0) begin : g_first
         assign stage_in = d;
      end else begin : g_next
         assign stage_in = stage_q[i-1];
      end

      d_flip_flop_cell #(
         .WIDTH       (WIDTH),
         .RESET_VALUE (RESET_VALUE),
         .USE_EN      (USE_EN)
      ) u_cell (
         .clk  (clk),
         .rst  (rst),
         .en_i (en),
         .d_i  (stage_in),
         .q_o  (stage_q[i])
      );
   end

   assign q   = stage_q[STAGES-1];
   assign q_n = ~q;

endmodule : d_flip_flop

// File: tb/tb_d_flip_flop.sv
// Directed bench for d_flip_flop across four parameter sets, scoreboard-checked.
module tb_d_flip_flop;

   logic clk = 1'b0;
   always #10 clk = ~clk;

   // default: 1-bit, single stage
   logic       rst0, en0, d0, q0, qn0;
   // USE_EN=1, WIDTH=8
   logic       rst1, en1;
   logic [7:0] d1, q1, qn1;
   // STAGES=3, WIDTH=4
   logic       rst3, en3;
   logic [3:0] d3, q3, qn3;
   // RESET_VALUE=F, WIDTH=4
   logic       rstf, enf;
   logic [3:0] df, qf, qnf;

   d_flip_flop u_dut0 (
      .clk(clk), .rst(rst0), .en(en0), .d(d0), .q(q0), .q_n(qn0)
   );

   d_flip_flop #(.WIDTH(8), .USE_EN(1'b1)) u_dut_en (
      .clk(clk), .rst(rst1), .en(en1), .d(d1), .q(q1), .q_n(qn1)
   );

   d_flip_flop #(.WIDTH(4), .STAGES(3)) u_dut_s3 (
      .clk(clk), .rst(rst3), .en(en3), .d(d3), .q(q3), .q_n(qn3)
   );

   d_flip_flop #(.WIDTH(4), .RESET_VALUE(4'hF)) u_dut_rv (
      .clk(clk), .rst(rstf), .en(enf), .d(df), .q(qf), .q_n(qnf)
   );

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   logic [7:0] sb[$];
   logic [7:0] exp_cur;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic expect_q(input logic [7:0] v);
      sb.push_back(v);
   endtask

   task automatic sb_pop(input string tag, output logic [7:0] v);
      if (sb.size() == 0) begin
         n_total++;
         n_fail++;
         $error("FAIL %s: got empty scoreboard expected an entry", tag);
         v = 'x;
      end else begin
         v = sb.pop_front();
      end
   endtask

   task automatic sb_check(input string tag, input logic [7:0] obs);
      logic [7:0] e;
      sb_pop(tag, e);
      check(tag, obs, e);
   endtask

   task automatic step();
      @(posedge clk);
      #5;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst0 = 1'b1; en0 = 1'b1; d0 = 1'b0;
      rst1 = 1'b1; en1 = 1'b0; d1 = 8'h00;
      rst3 = 1'b1; en3 = 1'b1; d3 = 4'h0;
      rstf = 1'b1; enf = 1'b1; df = 4'h0;

      // Reset on the first edge for every instance.
      step();
      check("rst_q0",   {7'b0, q0},  8'h00);
      check("rst_qn0",  {7'b0, qn0}, 8'h01);
      check("rst_q_en", q1,          8'h00);
      check("rst_q_s3", {4'b0, q3},  8'h00);
      check("rst_q_rv", {4'b0, qf},  8'h0F);
      check("rst_qn_rv",{4'b0, qnf}, 8'h00);

      // Release reset with d=0, then align so d toggles 3ns after an edge, every 25ns.
      rst0 = 1'b0;
      expect_q({7'b0, d0});
      @(posedge clk);
      #3;
      sb_pop("tog_start", exp_cur);
      check("tog_start", {7'b0, q0}, exp_cur);

      // Ticks every 5ns never land on an edge; an edge falls in the tick window when 5j%20==15.
      for (int j = 0; j < 85; j++) begin
         if (j % 5 == 0) d0 = ~d0;
         if ((5 * j) % 20 == 15) begin
            expect_q({7'b0, d0});
            #5;
            sb_pop("tog_edge", exp_cur);
         end else begin
            #5;
         end
         check("tog_q",  {7'b0, q0},  exp_cur);
         check("tog_qn", {7'b0, qn0}, {7'b0, ~exp_cur[0]});
      end

      // Reset beats d=1, then d=1 is captured once reset drops.
      d0 = 1'b1; rst0 = 1'b1;
      expect_q(8'h00);
      step();
      sb_check("rst_d1", {7'b0, q0});
      rst0 = 1'b0;
      expect_q(8'h01);
      step();
      sb_check("rel_d1", {7'b0, q0});

      // Enable gating, 8-bit.
      rst1 = 1'b0; en1 = 1'b1; d1 = 8'hA5;
      expect_q(8'hA5);
      step();
      sb_check("en_a5", q1);
      d1 = 8'h3C; en1 = 1'b0;
      for (int k = 0; k < 3; k++) begin
         expect_q(8'hA5);
         step();
         sb_check("en_hold", q1);
      end
      en1 = 1'b1;
      expect_q(8'h3C);
      step();
      sb_check("en_3c", q1);
      rst1 = 1'b1; en1 = 1'b0;
      expect_q(8'h00);
      step();
      sb_check("en_rst", q1);
      check("en_rst_qn", qn1, 8'hFF);
      rst1 = 1'b0; d1 = 8'h77;
      expect_q(8'h00);
      step();
      sb_check("en_hold_after_rst", q1);

      // Three-stage delay line: the chain starts holding two reset zeros.
      rst3 = 1'b0;
      expect_q(8'h00);
      expect_q(8'h00);
      for (int k = 1; k <= 5; k++) begin
         d3 = 4'(k);
         expect_q(8'(k));
         step();
         sb_check("s3_pipe", {4'b0, q3});
      end
      rst3 = 1'b1; d3 = 4'h6;
      sb.delete();
      expect_q(8'h00);
      step();
      sb_check("s3_rst", {4'b0, q3});
      rst3 = 1'b0; d3 = 4'h0;
      expect_q(8'h00);
      expect_q(8'h00);
      for (int k = 0; k < 3; k++) begin
         expect_q(8'h00);
         step();
         sb_check("s3_flushed", {4'b0, q3});
      end
      sb.delete();

      // Non-zero reset value and mid-cycle glitches on d.
      rstf = 1'b0; df = 4'h6;
      expect_q(8'h06);
      step();
      sb_check("rv_cap6", {4'b0, qf});
      df = 4'h9; #2; df = 4'hA; #2; df = 4'h6; #2; df = 4'h1; #2;
      check("rv_glitch_q", {4'b0, qf}, 8'h06);
      df = 4'hC;
      expect_q(8'h0C);
      step();
      sb_check("rv_capc", {4'b0, qf});
      rstf = 1'b1;
      expect_q(8'h0F);
      step();
      sb_check("rv_rst", {4'b0, qf});
      check("rv_rst_qn", {4'b0, qnf}, 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_d_flip_flop
